hazard_unit: RTL
================

// Module: hazard_unit
// PURPOSE
//   Parametrised pipeline-control unit for the in-order RV32 core. Generates per-stage stall, bubble
//   and kill controls, plus invalid-instruction trap sequencing. Keeps a shadow pipeline of in-flight
//   destination registers to detect RAW hazards. Sits beside decode; consumes the decoded ctrl fields
//   (invalid, jump) and drives the bubble/kill fields of ctrl_t for every stage.
// PARAMETERS
//   STAGES  5  total pipeline depth (IF,ID,EX,...,WB); legal 4..8; shadow depth SD = STAGES-2
//   BYPASS  1  1: forwarding present, stall only on load-use; 0: stall on any RAW to an in-flight rd
//   RW      5  register-address width
// PORTS
//   clk          in   1       core clock, rising edge
//   resetn       in   1       asynchronous active-low reset
//   id_valid     in   1       ID holds a real instruction
//   id_rs1       in   RW      ID source 1 address
//   id_rs1_used  in   1       instruction reads rs1
//   id_rs2       in   RW      ID source 2 address
//   id_rs2_used  in   1       instruction reads rs2
//   id_rd        in   RW      ID destination address
//   id_rd_we     in   1       instruction writes rd
//   id_is_load   in   1       instruction is a load
//   id_invalid   in   1       ctrl_t.invalid from decoder
//   ex_jump      in   1       taken jump/branch resolved in EX; held by EX while frozen
//   dmem_ready   in   1       MEM stage may advance; 0 freezes whole pipeline
//   stall_if     out  1       hold PC / IF register
//   stall_id     out  1       hold ID register
//   bubble_ex    out  1       load a NOP into EX this edge
//   kill_if      out  1       squash IF contents (becomes bubble in ID)
//   kill_id      out  1       squash ID contents (becomes bubble in EX)
//   freeze       out  1       all stage registers hold
//   trap         out  1       core halted on invalid instruction
//   pipe_valid   out  STAGES  valid bit per stage, [0]=IF
// BEHAVIOUR
//   Reset: all outputs 0; shadow entries invalid; state RUN. Async assert, sync release via flops.
//   Shadow pipe: SD entries {valid,rd,we,load} for EX..WB. Advances when freeze=0:
//     entry[0] <= ID fields if id_valid & ~stall & ~kill_id, else invalid; entry[i] <= entry[i-1].
//   freeze = ~dmem_ready. While frozen: shadow holds; stall_*/bubble/kill forced 0.
//   RAW match(e) = e.valid & e.we & e.rd!=0 & ((rs1_used & rs1==e.rd) | (rs2_used & rs2==e.rd)).
//     BYPASS=1: hazard = id_valid & match(entry[0]) & entry[0].load.
//     BYPASS=0: hazard = id_valid & OR of match(entry[0..SD-2]); WB writes before ID reads.
//   Hazard (not frozen, no jump): stall_if=stall_id=bubble_ex=1. All combinational, 0-cycle latency.
//   ex_jump (not frozen): kill_if=kill_id=1; stall/bubble suppressed.
//     Jump beats hazard: the dependent instruction is squashed.
//   FSM RUN/DRAIN/HALT:
//     RUN->DRAIN: on the edge an id_invalid instruction would enter EX (id_valid, no stall/kill/freeze).
//       That instruction enters shadow as invalid (never executes).
//     DRAIN: stall_if=stall_id=1, bubble_ex=1; older entries retire normally. Jump in DRAIN is ignored.
//     DRAIN->HALT: once all shadow entries invalid.
//     HALT: trap=1, stall_if=stall_id=1, pipe_valid=0; exits only by reset.
//   pipe_valid: [0]=~HALT, [1]=id_valid, [2..]=shadow valid bits.
//   Reset mid-operation: immediate return to RUN with empty shadow regardless of state.
// STRUCTURE
//   Package ctrl gains: hz_state_t enum {RUN,DRAIN,HALT}; sb_entry_t struct {valid,rd,we,load};
//   stage index localparams (IF=0,ID=1,EX=2).
//   Sub-module hazard_shadow_pipe: SD-deep sb_entry_t shift register with hold/insert-bubble inputs.
//   Comparators and FSM stay in hazard_unit.
// TESTING
//   1) BYPASS=1: lw x5 in EX, ID add x6,x5,x1 -> stall_if=stall_id=bubble_ex=1 one cycle, then 0.
//   2) BYPASS=0, STAGES=5: add x5 enters EX, dependent in ID -> stall 2 cycles (EX,MEM), release at WB.
//   3) Hazard plus ex_jump same cycle -> kill_if=kill_id=1, stall_id=bubble_ex=0.
//   4) dmem_ready=0 for 3 cycles during load-use -> freeze=1, stall/kill=0, shadow unchanged; resumes.
//   5) Invalid in ID, two valid older ops -> DRAIN 2 cycles, then trap=1 held; resetn low -> all 0.
//   6) rd=x0 producer, consumer reads x0 -> no stall in either BYPASS mode.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: FSM states, shadow-pipe entry
// layout, stage indices and the RAW comparator.
package hazard_unit_pkg;

    // Widest register address the shadow entries can carry; RW must not exceed it.
    localparam int RD_MAXW = 8;

    localparam int IF = 0;
    localparam int ID = 1;
    localparam int EX = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic               valid;
        logic [RD_MAXW-1:0] rd;
        logic               we;
        logic               load;
    } sb_entry_t;

    // x0 never carries a dependency, whatever the producer claims.
    function automatic logic raw_match(
        input sb_entry_t          e,
        input logic [RD_MAXW-1:0] rs1,
        input logic               rs1_used,
        input logic [RD_MAXW-1:0] rs2,
        input logic               rs2_used
    );
        return e.valid && e.we && (e.rd != '0) &&
               ((rs1_used && (rs1 == e.rd)) || (rs2_used && (rs2 == e.rd)));
    endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of the destination fields of instructions in EX..WB.
// Holds while frozen; a bubble inserts an invalid entry at EX.
module hazard_shadow_pipe
    import hazard_unit_pkg::*;
#(
    parameter int SD = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_hold,
    input  logic                 i_bubble,
    input  sb_entry_t            i_entry,
    output sb_entry_t [SD-1:0]   o_entries
);

    sb_entry_t [SD-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (!i_hold) begin
            r_q[0] <= i_bubble ? sb_entry_t'('0) : i_entry;
            for (int i = 1; i < SD; i++) begin
                r_q[i] <= r_q[i-1];
            end
        end
    end

    assign o_entries = r_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline control for the in-order core: RAW stalls from a shadow pipe,
// jump kills, memory freeze and invalid-instruction drain/trap sequencing.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int STAGES = 5,
    parameter int BYPASS = 1,
    parameter int RW     = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              id_valid,
    input  logic [RW-1:0]     id_rs1,
    input  logic              id_rs1_used,
    input  logic [RW-1:0]     id_rs2,
    input  logic              id_rs2_used,
    input  logic [RW-1:0]     id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              id_invalid,
    input  logic              ex_jump,
    input  logic              dmem_ready,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              kill_if,
    output logic              kill_id,
    output logic              freeze,
    output logic              trap,
    output logic [STAGES-1:0] pipe_valid
);

    localparam int SD = STAGES - 2;

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    hz_state_t          r_state;
    sb_entry_t [SD-1:0] w_sh;
    sb_entry_t          w_ins;
    logic [RD_MAXW-1:0] w_rs1;
    logic [RD_MAXW-1:0] w_rs2;
    logic [RD_MAXW-1:0] w_rd;
    logic               w_hazard;
    logic               w_older_busy;
    logic               w_bubble_in;
    logic               w_unused;

    // Reset asserts immediately, releases two edges after resetn rises.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_rs1 = RD_MAXW'(id_rs1);
    assign w_rs2 = RD_MAXW'(id_rs2);
    assign w_rd  = RD_MAXW'(id_rd);

    // The WB entry has already written the register file before ID reads it.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < SD-1; i++) begin
            if (raw_match(w_sh[i], w_rs1, id_rs1_used, w_rs2, id_rs2_used) &&
                ((BYPASS == 0) || ((i == 0) && w_sh[i].load))) begin
                w_hazard = 1'b1;
            end
        end
        w_hazard = w_hazard & id_valid;
    end

    always_comb begin
        w_older_busy = 1'b0;
        for (int i = 0; i < SD-1; i++) begin
            w_older_busy = w_older_busy | w_sh[i].valid;
        end
    end

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        kill_if   = 1'b0;
        kill_id   = 1'b0;
        if (w_rst_n && dmem_ready) begin
            unique case (r_state)
                RUN: begin
                    if (ex_jump) begin
                        kill_if = 1'b1;
                        kill_id = 1'b1;
                    end else if (w_hazard) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end
                end
                DRAIN: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
                HALT: begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign freeze = w_rst_n & ~dmem_ready;
    assign trap   = w_rst_n & (r_state == HALT);

    // An invalid instruction is dropped on its way into EX so it never executes.
    assign w_bubble_in = ~(id_valid & ~id_invalid & ~stall_id & ~kill_id & (r_state == RUN));
    assign w_ins       = '{valid: 1'b1, rd: w_rd, we: id_rd_we, load: id_is_load};

    hazard_shadow_pipe #(.SD(SD)) u_shadow (
        .clk       (clk),
        .rst_n     (w_rst_n),
        .i_hold    (~dmem_ready),
        .i_bubble  (w_bubble_in),
        .i_entry   (w_ins),
        .o_entries (w_sh)
    );

    // DRAIN ends on the edge that empties the shadow: EX already receives
    // bubbles, so only entries ahead of WB can still be occupied afterwards.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= RUN;
        end else if (dmem_ready) begin
            unique case (r_state)
                RUN: begin
                    if (id_valid && id_invalid && !ex_jump && !w_hazard) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!w_older_busy) begin
                        r_state <= HALT;
                    end
                end
                HALT:    r_state <= HALT;
                default: r_state <= RUN;
            endcase
        end
    end

    always_comb begin
        pipe_valid = '0;
        if (w_rst_n && (r_state != HALT)) begin
            pipe_valid[IF] = 1'b1;
            pipe_valid[ID] = id_valid;
            for (int i = 0; i < SD; i++) begin
                pipe_valid[EX+i] = w_sh[i].valid;
            end
        end
    end

    assign w_unused = ^{w_sh[SD-1].rd, w_sh[SD-1].we, w_sh[SD-1].load};

endmodule
